// File: rtl/unit_splitter.sv
// One-entry steering register: a wide word is held and presented to either the buffer
// path or the matrix unit input. Optional UNIT_SPLITTER_BROADCAST_EN adds a send-to-both mode.
module unit_splitter #(
    parameter int DATA_SIZE  = 16,
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            selector,
`ifdef UNIT_SPLITTER_BROADCAST_EN
    input  logic                            broadcast,
`endif
    input  logic [DATA_SIZE*DATA_WIDTH-1:0] datsIn,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [DATA_SIZE*DATA_WIDTH-1:0] out_buffer,
    output logic                            out_buffer_valid,
    input  logic                            out_buffer_ready,
    output logic [DATA_SIZE*DATA_WIDTH-1:0] out_matrix,
    output logic                            out_matrix_valid,
    input  logic                            out_matrix_ready,
    output logic [CNT_WIDTH-1:0]            buf_count,
    output logic [CNT_WIDTH-1:0]            mat_count
);

    localparam int W = DATA_SIZE * DATA_WIDTH;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_BUF   = 2'd1,
        S_MAT   = 2'd2
`ifdef UNIT_SPLITTER_BROADCAST_EN
        , S_BOTH = 2'd3
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [W-1:0]         hold_q, hold_d;
    logic [CNT_WIDTH-1:0] buf_cnt_q, buf_cnt_d;
    logic [CNT_WIDTH-1:0] mat_cnt_q, mat_cnt_d;
    logic                 buf_done, mat_done, accept;
`ifdef UNIT_SPLITTER_BROADCAST_EN
    // Per-side outstanding flags, only meaningful while in S_BOTH.
    logic                 pend_buf_q, pend_buf_d;
    logic                 pend_mat_q, pend_mat_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_EMPTY;
            hold_q    <= '0;
            buf_cnt_q <= '0;
            mat_cnt_q <= '0;
`ifdef UNIT_SPLITTER_BROADCAST_EN
            pend_buf_q <= 1'b0;
            pend_mat_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            buf_cnt_q <= buf_cnt_d;
            mat_cnt_q <= mat_cnt_d;
`ifdef UNIT_SPLITTER_BROADCAST_EN
            pend_buf_q <= pend_buf_d;
            pend_mat_q <= pend_mat_d;
`endif
        end
    end

    always_comb begin
        state_d          = state_q;
        hold_d           = hold_q;
        out_buffer_valid = (state_q == S_BUF);
        out_matrix_valid = (state_q == S_MAT);
`ifdef UNIT_SPLITTER_BROADCAST_EN
        out_buffer_valid = out_buffer_valid | ((state_q == S_BOTH) & pend_buf_q);
        out_matrix_valid = out_matrix_valid | ((state_q == S_BOTH) & pend_mat_q);
`endif
        buf_done = out_buffer_valid & out_buffer_ready;
        mat_done = out_matrix_valid & out_matrix_ready;

        // in_ready means "the slot is free by the end of this cycle".
        case (state_q)
            S_EMPTY: in_ready = 1'b1;
            S_BUF:   in_ready = out_buffer_ready;
            S_MAT:   in_ready = out_matrix_ready;
`ifdef UNIT_SPLITTER_BROADCAST_EN
            S_BOTH:  in_ready = (~pend_buf_q | out_buffer_ready) & (~pend_mat_q | out_matrix_ready);
`endif
            default: in_ready = 1'b0;
        endcase
        accept = in_valid & in_ready;

`ifdef UNIT_SPLITTER_BROADCAST_EN
        pend_buf_d = pend_buf_q & ~buf_done;
        pend_mat_d = pend_mat_q & ~mat_done;
`endif
        if (accept) begin
            hold_d  = datsIn;
            state_d = selector ? S_BUF : S_MAT;
`ifdef UNIT_SPLITTER_BROADCAST_EN
            if (broadcast) state_d = S_BOTH;
            pend_buf_d = 1'b1;
            pend_mat_d = 1'b1;
`endif
        end else if (in_ready) begin
            state_d = S_EMPTY;
        end

        buf_cnt_d = buf_cnt_q + CNT_WIDTH'(buf_done);
        mat_cnt_d = mat_cnt_q + CNT_WIDTH'(mat_done);
    end

    assign out_buffer = hold_q;
    assign out_matrix = hold_q;
    assign buf_count  = buf_cnt_q;
    assign mat_count  = mat_cnt_q;

endmodule

// File: tb/tb_unit_splitter.sv
// Randomised scoreboard bench for unit_splitter; expected words sit in per-destination
// queues and the monitor checks every cycle against the queue-level model.
module tb_unit_splitter;

    localparam int DS = 16;
    localparam int DW = 8;
    localparam int CW = 4;
    localparam int W  = DS * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          selector, in_valid, in_ready;
    logic          broadcast;
    logic [W-1:0]  datsIn, out_buffer, out_matrix;
    logic          out_buffer_valid, out_buffer_ready;
    logic          out_matrix_valid, out_matrix_ready;
    logic [CW-1:0] buf_count, mat_count;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0]  q_buf[$];
    logic [W-1:0]  q_mat[$];
    logic [CW-1:0] exp_buf = '0;
    logic [CW-1:0] exp_mat = '0;
    bit            mon_en = 1'b0;

    always #5 clk = ~clk;

    unit_splitter #(.DATA_SIZE(DS), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .selector(selector),
`ifdef UNIT_SPLITTER_BROADCAST_EN
        .broadcast(broadcast),
`endif
        .datsIn(datsIn), .in_valid(in_valid), .in_ready(in_ready),
        .out_buffer(out_buffer), .out_buffer_valid(out_buffer_valid), .out_buffer_ready(out_buffer_ready),
        .out_matrix(out_matrix), .out_matrix_valid(out_matrix_valid), .out_matrix_ready(out_matrix_ready),
        .buf_count(buf_count), .mat_count(mat_count)
    );

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rw();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Monitor: the slot is free when every destination still owed the word is ready.
    always @(negedge clk) begin
        logic er;
        #2;
        if (mon_en && !rst) begin
            er = (q_buf.size() == 0 || out_buffer_ready) && (q_mat.size() == 0 || out_matrix_ready);
            chk("in_ready", W'(in_ready), W'(er));
            chk("buf_valid", W'(out_buffer_valid), W'(q_buf.size() > 0));
            chk("mat_valid", W'(out_matrix_valid), W'(q_mat.size() > 0));
            chk("buf_count", W'(buf_count), W'(exp_buf));
            chk("mat_count", W'(mat_count), W'(exp_mat));
            if (out_buffer_valid && q_buf.size() > 0) begin
                chk("buf_data", out_buffer, q_buf[0]);
                if (out_buffer_ready) begin
                    void'(q_buf.pop_front());
                    exp_buf = exp_buf + 1'b1;
                end
            end
            if (out_matrix_valid && q_mat.size() > 0) begin
                chk("mat_data", out_matrix, q_mat[0]);
                if (out_matrix_ready) begin
                    void'(q_mat.pop_front());
                    exp_mat = exp_mat + 1'b1;
                end
            end
        end
    end

    task automatic cyc(input bit iv, input bit sel, input bit bc, input logic [W-1:0] d,
                       input bit br, input bit mr);
        bit acc, bce;
        @(negedge clk);
        in_valid = iv; selector = sel; datsIn = d; broadcast = bc;
        out_buffer_ready = br; out_matrix_ready = mr;
`ifdef UNIT_SPLITTER_BROADCAST_EN
        bce = bc;
`else
        bce = 1'b0;
`endif
        #1;
        acc = in_valid && in_ready;
        @(posedge clk);
        if (acc) begin
            if (bce) begin
                q_buf.push_back(d);
                q_mat.push_back(d);
            end else if (sel) q_buf.push_back(d);
            else q_mat.push_back(d);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_buf_valid", W'(out_buffer_valid), '0);
        chk("rst_mat_valid", W'(out_matrix_valid), '0);
        chk("rst_buf_count", W'(buf_count), '0);
        chk("rst_mat_count", W'(mat_count), '0);
        q_buf.delete();
        q_mat.delete();
        exp_buf = '0;
        exp_mat = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0] w, a5;
        rst = 1'b1; in_valid = 1'b0; selector = 1'b0; broadcast = 1'b0; datsIn = '0;
        out_buffer_ready = 1'b0; out_matrix_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        #1;
        chk("reset_in_ready", W'(in_ready), W'(1));
        chk("reset_hold", out_buffer, '0);
        chk("reset_valids", W'({out_buffer_valid, out_matrix_valid}), '0);
        chk("reset_counts", W'({buf_count, mat_count}), '0);
        repeat (2) cyc(0, 0, 0, '0, 0, 0);

        a5 = {(W/8){8'hA5}};
        cyc(1, 1, 0, a5, 1, 0);
        cyc(0, 0, 0, '0, 1, 0);
        cyc(0, 0, 0, '0, 1, 0);
        #1;
        chk("a5_buf_count", W'(buf_count), W'(1));
        chk("a5_mat_count", W'(mat_count), W'(0));

        // Matrix stall for 5 cycles while a second word is offered and must be refused.
        cyc(1, 0, 0, rw(), 1, 0);
        repeat (5) cyc(1, 1, 0, rw(), 1, 0);
        cyc(0, 0, 0, '0, 0, 1);
        cyc(0, 0, 0, '0, 1, 1);
        #1;
        chk("stall_mat_count", W'(mat_count), W'(1));
        chk("stall_buf_count", W'(buf_count), W'(1));

        do_reset();
        for (int i = 0; i < 8; i++) cyc(1, (i % 2) == 0, 0, rw(), 1, 1);
        cyc(0, 0, 0, '0, 1, 1);
        #1;
        chk("alt_buf_count", W'(buf_count), W'(4));
        chk("alt_mat_count", W'(mat_count), W'(4));

        do_reset();
        for (int i = 0; i < 17; i++) cyc(1, 1, 0, rw(), 1, 0);
        cyc(0, 0, 0, '0, 1, 0);
        #1;
        chk("wrap_buf_count", W'(buf_count), W'(1));

        w = rw();
        cyc(1, 0, 0, w, 0, 0);
        repeat (2) cyc(0, 0, 0, '0, 0, 0);
        do_reset();

        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                rw(), $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
        repeat (4) cyc(0, 0, 0, '0, 1, 1);

`ifdef UNIT_SPLITTER_BROADCAST_EN
        do_reset();
        w = rw();
        cyc(1, 0, 1, w, 0, 0);
        cyc(0, 0, 0, '0, 0, 1);
        repeat (2) cyc(1, 1, 0, rw(), 0, 0);
        cyc(0, 0, 0, '0, 1, 0);
        cyc(0, 0, 0, '0, 0, 0);
        #1;
        chk("bc_buf_count", W'(buf_count), W'(1));
        chk("bc_mat_count", W'(mat_count), W'(1));
        chk("bc_in_ready", W'(in_ready), W'(1));
`endif

        repeat (2) cyc(0, 0, 0, '0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
